// File: rtl/sc_node_rr_arbiter.sv
// N:1 round-robin arbiter sharing one SC channel node between NUM_SI sources,
// with optional whole-packet grant lock and a one-entry registered output stage.
module sc_node_rr_arbiter #(
  parameter int NUM_SI      = 4,
  parameter int PAYLD_WIDTH = 174,
  parameter int INFO_WIDTH  = 1,
  parameter int MULTI_BEAT  = 0,
  localparam int SRC_W      = (NUM_SI > 1) ? $clog2(NUM_SI) : 1
) (
  input  logic                          sc_aclk,
  input  logic                          sc_aresetn,
  input  logic [NUM_SI-1:0]             s_sc_req,
  input  logic [NUM_SI-1:0]             s_sc_send,
  output logic [NUM_SI-1:0]             s_sc_recv,
  input  logic [NUM_SI*INFO_WIDTH-1:0]  s_sc_info,
  input  logic [NUM_SI*PAYLD_WIDTH-1:0] s_sc_payld,
  output logic                          m_sc_req,
  output logic                          m_sc_send,
  input  logic                          m_sc_recv,
  output logic [INFO_WIDTH-1:0]         m_sc_info,
  output logic [PAYLD_WIDTH-1:0]        m_sc_payld,
  output logic [SRC_W-1:0]              m_sc_src
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t                 r_state;
  logic [SRC_W-1:0]       r_grant_idx;
  logic [SRC_W-1:0]       r_rr_ptr;
  logic [SRC_W-1:0]       r_out_src;
  logic                   r_out_valid;
  logic                   r_m_req;
  logic [INFO_WIDTH-1:0]  r_out_info;
  logic [PAYLD_WIDTH-1:0] r_out_payld;

  logic [NUM_SI-1:0]      w_cand;
  logic [SRC_W-1:0]       w_pick_idx;
  logic [SRC_W-1:0]       w_next_ptr;
  logic                   w_pick_vld;
  logic                   w_sel_send;
  logic                   w_out_free;
  logic                   w_load;
  logic                   w_last;
  logic [INFO_WIDTH-1:0]  w_sel_info;
  logic [PAYLD_WIDTH-1:0] w_sel_payld;

  assign w_cand = s_sc_req | s_sc_send;

  // Round-robin pick; offsets are scanned high-to-low so the smallest offset from r_rr_ptr wins.
  always_comb begin
    int v_idx;
    v_idx      = 0;
    w_pick_idx = '0;
    w_pick_vld = 1'b0;
    for (int off = NUM_SI - 1; off >= 0; off--) begin
      v_idx      = int'(r_rr_ptr) + off;
      v_idx      = (v_idx >= NUM_SI) ? (v_idx - NUM_SI) : v_idx;
      w_pick_idx = w_cand[SRC_W'(v_idx)] ? SRC_W'(v_idx) : w_pick_idx;
      w_pick_vld = w_pick_vld | w_cand[SRC_W'(v_idx)];
    end
  end

  // AND-OR mux of the granted source's beat, and per-source accept back toward it.
  always_comb begin
    logic v_hit;
    v_hit       = 1'b0;
    w_sel_send  = 1'b0;
    w_sel_info  = '0;
    w_sel_payld = '0;
    s_sc_recv   = '0;
    for (int i = 0; i < NUM_SI; i++) begin
      v_hit        = (r_grant_idx == SRC_W'(i));
      w_sel_send   = w_sel_send | (s_sc_send[i] & v_hit);
      w_sel_info   = w_sel_info | ({INFO_WIDTH{v_hit}} & s_sc_info[i*INFO_WIDTH +: INFO_WIDTH]);
      w_sel_payld  = w_sel_payld | ({PAYLD_WIDTH{v_hit}} & s_sc_payld[i*PAYLD_WIDTH +: PAYLD_WIDTH]);
      s_sc_recv[i] = (r_state == ST_GRANT) & v_hit & w_out_free;
    end
  end

  // The output slot can take a beat when empty or when it drains this same cycle.
  assign w_out_free = ~r_out_valid | m_sc_recv;
  assign w_load     = (r_state == ST_GRANT) & w_sel_send & w_out_free;
  assign w_last     = (MULTI_BEAT == 0) ? 1'b1 : w_sel_info[0];
  assign w_next_ptr = (r_grant_idx == SRC_W'(NUM_SI - 1)) ? '0 : (r_grant_idx + 1'b1);

  // Arbitration FSM: pick in IDLE, hold the grant until the packet's last beat is taken.
  always_ff @(posedge sc_aclk or negedge sc_aresetn) begin
    if (!sc_aresetn) begin
      r_state     <= ST_IDLE;
      r_grant_idx <= '0;
      r_rr_ptr    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_vld) begin
            r_grant_idx <= w_pick_idx;
            r_state     <= ST_GRANT;
          end else begin
            r_state     <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (w_load && w_last) begin
            r_rr_ptr <= w_next_ptr;
            r_state  <= ST_IDLE;
          end else begin
            r_state  <= ST_GRANT;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // One-entry output stage; a load and a drain in the same cycle keep it full.
  always_ff @(posedge sc_aclk or negedge sc_aresetn) begin
    if (!sc_aresetn) begin
      r_out_valid <= 1'b0;
      r_out_info  <= '0;
      r_out_payld <= '0;
      r_out_src   <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_info  <= w_sel_info;
      r_out_payld <= w_sel_payld;
      r_out_src   <= r_grant_idx;
    end else if (m_sc_recv) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  // Downstream request hint, independent of the FSM.
  always_ff @(posedge sc_aclk or negedge sc_aresetn) begin
    if (!sc_aresetn) begin
      r_m_req <= 1'b0;
    end else begin
      r_m_req <= |s_sc_req;
    end
  end

  assign m_sc_req   = r_m_req;
  assign m_sc_send  = r_out_valid;
  assign m_sc_info  = r_out_info;
  assign m_sc_payld = r_out_payld;
  assign m_sc_src   = r_out_src;

endmodule

// File: doc/sc_node_rr_arbiter.md
Name: sc_node_rr_arbiter

Overview:
- N:1 round-robin arbiter that shares one SC channel node input (for example the AW, AR or W node of an SI node group) between NUM_SI requesters.
- Uses the native SC req/send/recv/info/payld handshake on both sides.
- Locks the grant for a full packet when MULTI_BEAT=1, so W bursts are never interleaved.
- Drives a one-entry registered output stage toward the downstream node.

Parameters:
- NUM_SI, 4: number of requesting sources, 2..16.
- PAYLD_WIDTH, 174: payload width per source (174 for AW/AR, 592 for W).
- INFO_WIDTH, 1: info width; info[0] is the last-beat flag.
- MULTI_BEAT, 0: 1 means hold the grant until a beat with info[0]=1 transfers; 0 means re-arbitrate after every beat.

Ports:
- sc_aclk  in  1  single clock; all logic is on the rising edge.
- sc_aresetn  in  1  asynchronous, active-low reset.
- s_sc_req  in  NUM_SI  per-source pending-request indication.
- s_sc_send  in  NUM_SI  per-source beat valid.
- s_sc_recv  out  NUM_SI  per-source beat accepted.
- s_sc_info  in  NUM_SI*INFO_WIDTH  per-source info, packed with source i at [i*INFO_WIDTH +: INFO_WIDTH].
- s_sc_payld  in  NUM_SI*PAYLD_WIDTH  per-source payload, packed the same way.
- m_sc_req  out  1  registered OR of s_sc_req.
- m_sc_send  out  1  output beat valid.
- m_sc_recv  in  1  downstream accepts the beat.
- m_sc_info  out  INFO_WIDTH  info of the output beat.
- m_sc_payld  out  PAYLD_WIDTH  payload of the output beat.
- m_sc_src  out  clog2(NUM_SI)  index of the source of the current output beat.

Behaviour:
- Handshake rules:
  - A transfer occurs when send&recv are both high in the same cycle, on either side.
  - send, once asserted, must hold with stable payld/info until recv; the arbiter obeys this on the m side.
- Reset values, applied asynchronously while sc_aresetn=0:
  - s_sc_recv=0, m_sc_send=0, m_sc_req=0, m_sc_info=0, m_sc_payld=0, m_sc_src=0.
  - FSM=IDLE, rr_ptr=0.
- Reset mid-packet: the in-flight beat and the lock are discarded; after release the arbiter is in IDLE with rr_ptr=0.
- FSM IDLE:
  - Candidate set is s_sc_req|s_sc_send.
  - If the set is non-empty, pick the first set bit searching upward from rr_ptr with wrap-around (NUM_SI-1 wraps to 0).
  - Register the pick as grant_idx and go to GRANT.
  - s_sc_recv is all-zero in IDLE.
- FSM GRANT:
  - s_sc_recv[grant_idx] = !out_valid | m_sc_recv (combinational from m_sc_recv); all other bits are 0.
  - An accepted beat loads the output register: m_sc_send=1, payld/info copied, m_sc_src=grant_idx.
  - Leave GRANT on the accepted beat when MULTI_BEAT=0, or when MULTI_BEAT=1 and info[0]=1. On exit: rr_ptr <= (grant_idx+1) mod NUM_SI, go to IDLE.
  - If the granted source drops both req and send before its last beat in MULTI_BEAT=1 mode, the lock is held indefinitely. There is no timeout; this is a protocol violation on the requester.
- Output register:
  - m_sc_send is cleared when m_sc_recv=1 and no new beat is loaded that cycle.
  - A load and a drain in the same cycle keep m_sc_send=1 with the new beat.
- Latency:
  - Source send rises at cycle N while in IDLE.
  - grant_idx is registered at N+1, and s_sc_recv is high at N+1 if the output register is free.
  - The beat appears on m_sc_send at N+2.
- Throughput:
  - One beat per cycle within a locked packet while m_sc_recv=1.
  - One IDLE bubble cycle between grants.
- Simultaneous events:
  - Requests arriving during GRANT are only considered at the next IDLE.
  - Only source grant_idx may transfer in a given cycle.
- m_sc_req: registered |s_sc_req, one cycle of latency, independent of the FSM.

Test Plan:
- Reset/idle: hold sc_aresetn=0 for 3 cycles with s_sc_send=4'b1111 -> all outputs 0 throughout. After release, the first grant goes to source 0 (rr_ptr=0).
- Fairness (MULTI_BEAT=0, m_sc_recv=1): all 4 sources send continuously -> m_sc_src sequence 0,1,2,3,0,… with one bubble between beats and no source skipped.
- Wrap-around: rr_ptr=3 and only source 1 requesting -> the search wraps and grants source 1; rr_ptr becomes 2 after the beat.
- Burst lock (MULTI_BEAT=1): source 2 sends 4 beats with info[0]=1 on beat 4 while source 0 requests -> 4 contiguous beats from source 2, then a grant to source 3 or 0 per rr order. Source 0 is never interleaved inside the burst.
- Backpressure: m_sc_recv=0 for 5 cycles mid-burst -> m_sc_payld/m_sc_info stay stable, s_sc_recv[grant_idx]=0, and no beat is lost or duplicated once recv returns.
- Async reset mid-burst: sc_aresetn low after beat 2 of 4 -> outputs clear immediately, without waiting for a clock edge. After release, arbitration restarts at source 0 in IDLE.
